// File: rtl/register_file_pkg.sv
// Shared CPU datapath definitions: word/address sizes, logic levels,
// bench timing constants and the 4-bit instruction opcodes.
package register_file_pkg;

  localparam int BIT_DATA = 16;
  localparam int SZB_REG  = 4;
  localparam int SZB_INS  = 4;

  localparam logic ON  = 1'b1;
  localparam logic OFF = 1'b0;

  // Half clock period and post-edge sampling offset used by benches.
  localparam int SWITCH = 5;
  localparam int DELAY  = 1;

  typedef enum logic [3:0] {
    LOAD  = 4'h0,
    STORE = 4'h1,
    MOVE  = 4'h2,
    JUMP  = 4'h3,
    INV   = 4'h4,
    AND   = 4'h5,
    OR    = 4'h6,
    XOR   = 4'h7,
    XNOR  = 4'h8,
    COM   = 4'h9,
    SHR   = 4'hA,
    SHL   = 4'hB,
    ADD   = 4'hC,
    SUB   = 4'hD,
    MUL   = 4'hE,
    DIV   = 4'hF
  } opcode_t;

endpackage

// File: rtl/register_file.sv
// Multi-port register file: two combinational read ports, one synchronous
// write port and an internal move (mem[addr_rd] <= mem[addr_rs0]).
// Also reused as instruction storage with only port 0 connected.
module register_file
  import register_file_pkg::*;
#(
  parameter int BIT = BIT_DATA,
  parameter int SZB = SZB_REG
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           rd_we,
  input  logic           en_mv,
  input  logic [SZB-1:0] addr_rs0,
  input  logic [SZB-1:0] addr_rs1,
  input  logic [SZB-1:0] addr_rd,
  input  logic [BIT-1:0] rd,
  output logic [BIT-1:0] rs0,
  output logic [BIT-1:0] rs1
);

  localparam int DEPTH = 1 << SZB;

  logic [BIT-1:0] mem [DEPTH];
  logic [BIT-1:0] wr_data;
  logic           wr_any;

  // Shared write data: external write wins over move; the move source is
  // read from current storage, so it is the pre-edge value.
  always_comb begin
    wr_any  = rd_we | en_mv;
    wr_data = rd_we ? rd : mem[addr_rs0];
  end

  // One register per entry; only the entry selected by addr_rd may load.
  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    logic [BIT-1:0] q;
    logic           sel;

    assign sel = wr_any && (addr_rd == SZB'(g));

    // Reset clears the entry and overrides any concurrent write or move.
    always_ff @(posedge clock) begin
      if (reset) begin
        q <= '0;
      end else if (sel) begin
        q <= wr_data;
      end
    end

    assign mem[g] = q;
  end

  // Reads are purely combinational from storage; no write-through bypass.
  assign rs0 = mem[addr_rs0];
  assign rs1 = mem[addr_rs1];

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: reset, sequential store, table-driven
// move/priority/reset vectors, instruction-bank usage and idle cycles.
module tb_register_file;
  import register_file_pkg::*;

  logic        clock = 1'b0;
  logic        reset, rd_we, en_mv;
  logic [3:0]  addr_rs0, addr_rs1, addr_rd;
  logic [15:0] rd, rs0, rs1;

  int total = 0;
  int bad   = 0;

  register_file #(.BIT(16), .SZB(4)) dut (
    .clock    (clock),
    .reset    (reset),
    .rd_we    (rd_we),
    .en_mv    (en_mv),
    .addr_rs0 (addr_rs0),
    .addr_rs1 (addr_rs1),
    .addr_rd  (addr_rd),
    .rd       (rd),
    .rs0      (rs0),
    .rs1      (rs1)
  );

  always #SWITCH clock = ~clock;

  typedef struct {
    logic        rst, we, mv;
    logic [3:0]  a0, a1, ard;
    logic [15:0] d;
    logic [15:0] pre0, pre1, post0, post1;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input int idx, input logic [15:0] act,
                     input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic we, input logic mv,
                       input logic [3:0] a0, input logic [3:0] a1,
                       input logic [3:0] ard, input logic [15:0] d);
    reset = r; rd_we = we; en_mv = mv;
    addr_rs0 = a0; addr_rs1 = a1; addr_rd = ard; rd = d;
  endtask

  function automatic logic [15:0] ins_word(input int k);
    logic [3:0]  op;
    logic [11:0] fld;
    op  = opcode_t'(k[3:0]);
    fld = 12'h0A5 ^ 12'(k * 3);
    return {op, fld};
  endfunction

  initial begin
    vecs[0] = '{1'b0,1'b1,1'b0, 4'd3,4'd9,4'd3, 16'hA5A5, 16'h3333,16'h9999, 16'hA5A5,16'h9999};
    vecs[1] = '{1'b0,1'b1,1'b0, 4'd3,4'd9,4'd9, 16'h1234, 16'hA5A5,16'h9999, 16'hA5A5,16'h1234};
    vecs[2] = '{1'b0,1'b0,1'b1, 4'd3,4'd9,4'd9, 16'h0000, 16'hA5A5,16'h1234, 16'hA5A5,16'hA5A5};
    vecs[3] = '{1'b0,1'b0,1'b1, 4'd7,4'd7,4'd7, 16'hFFFF, 16'h7777,16'h7777, 16'h7777,16'h7777};
    vecs[4] = '{1'b0,1'b1,1'b1, 4'd2,4'd5,4'd5, 16'hBEEF, 16'h2222,16'h5555, 16'h2222,16'hBEEF};
    vecs[5] = '{1'b0,1'b0,1'b1, 4'd9,4'd5,4'd2, 16'h0F0F, 16'hA5A5,16'hBEEF, 16'hA5A5,16'hBEEF};
    vecs[6] = '{1'b0,1'b0,1'b0, 4'd2,4'd9,4'd2, 16'h5A5A, 16'hA5A5,16'hA5A5, 16'hA5A5,16'hA5A5};
    vecs[7] = '{1'b0,1'b0,1'b1, 4'd5,4'd6,4'd6, 16'h0000, 16'hBEEF,16'h6666, 16'hBEEF,16'hBEEF};
    vecs[8] = '{1'b1,1'b1,1'b0, 4'd5,4'd6,4'd5, 16'h1111, 16'hBEEF,16'hBEEF, 16'h0000,16'h0000};

    drive(1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 16'hFFFF);
    @(posedge clock);
    #DELAY;

    // Reset: every entry reads 0 on both ports.
    @(negedge clock);
    drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 16'h0000);
    for (int i = 0; i < 16; i++) begin
      addr_rs0 = 4'(i);
      addr_rs1 = 4'(15 - i);
      #DELAY;
      chk("reset_rs0", i, rs0, 16'h0000);
      chk("reset_rs1", i, rs1, 16'h0000);
    end

    // Sequential store; rs1 looks at the next, not yet written, entry.
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      drive(1'b0, 1'b1, 1'b0, 4'(i), 4'(i + 1), 4'(i), 16'(i * 16'h1111));
      #DELAY;
      chk("store_pre_rs0", i, rs0, 16'h0000);
      @(posedge clock);
      #DELAY;
      chk("store_rs0", i, rs0, 16'(i * 16'h1111));
      chk("store_rs1", i, rs1, 16'h0000);
    end

    // Table vectors: move, self-move, priority, reset override.
    for (int v = 0; v < 9; v++) begin
      @(negedge clock);
      drive(vecs[v].rst, vecs[v].we, vecs[v].mv, vecs[v].a0, vecs[v].a1,
            vecs[v].ard, vecs[v].d);
      #DELAY;
      chk("vec_pre_rs0", v, rs0, vecs[v].pre0);
      chk("vec_pre_rs1", v, rs1, vecs[v].pre1);
      @(posedge clock);
      #DELAY;
      chk("vec_post_rs0", v, rs0, vecs[v].post0);
      chk("vec_post_rs1", v, rs1, vecs[v].post1);
    end

    // After the reset vector every entry is 0 again.
    @(negedge clock);
    drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 16'h0000);
    for (int i = 0; i < 16; i++) begin
      addr_rs0 = 4'(i);
      #DELAY;
      chk("rst2_rs0", i, rs0, 16'h0000);
    end

    // Instruction-bank usage: same address on read port 0 and write port.
    for (int k = 0; k < 16; k++) begin
      @(negedge clock);
      drive(1'b0, 1'b1, 1'b0, 4'(k), 4'(k + 15), 4'(k), ins_word(k));
      #DELAY;
      chk("ins_pre_rs0", k, rs0, 16'h0000);
      @(posedge clock);
      #DELAY;
      chk("ins_rs0", k, rs0, ins_word(k));
      chk("ins_rs1", k, rs1, (k == 0) ? 16'h0000 : ins_word(k - 1));
    end

    // Idle cycles with changing rd: contents hold, reads follow addresses.
    for (int j = 0; j < 4; j++) begin
      @(negedge clock);
      drive(1'b0, 1'b0, 1'b0, 4'(3 * j + 1), 4'(14 - j), 4'(3 * j + 1),
            16'hC000 + 16'(j));
      #DELAY;
      chk("idle_pre_rs0", j, rs0, ins_word(3 * j + 1));
      chk("idle_pre_rs1", j, rs1, ins_word(14 - j));
      @(posedge clock);
      #DELAY;
      chk("idle_rs0", j, rs0, ins_word(3 * j + 1));
      chk("idle_rs1", j, rs1, ins_word(14 - j));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
